// File: rtl/counter_pkg.sv
// counter_pkg: shared direction constants, modulo next-state helper and parameter check for counters
`define COUNTER_PARAMS_OK(W, M) ((W) >= 2 && (W) <= 16 && (M) >= 2 && (M) <= (1 << (W)))
package counter_pkg;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
  typedef struct packed {
    logic        wrap;
    logic [15:0] value;
  } mod_next_t;
  function automatic mod_next_t mod_next(input logic [15:0] count, input logic up, input int unsigned mod);
    logic [15:0] top;
    mod_next_t r;
    top = 16'(mod - 1);
    r.wrap = (up == DIR_UP) ? (count == top) : (count == 16'd0);
    r.value = r.wrap ? ((up == DIR_UP) ? 16'd0 : top) : ((up == DIR_UP) ? count + 16'd1 : count - 16'd1);
    return r;
  endfunction
endpackage

// File: rtl/t_ff_cell.sv
// t_ff_cell: single-bit toggle flip-flop with synchronous active-high reset
module t_ff_cell (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q,
  output logic qbar
);
  logic q_q;
  // flip the stored bit whenever t is high
  always_ff @(posedge clk) begin
    if (rst) q_q <= 1'b0;
    else if (t) q_q <= ~q_q;
  end
  assign q = q_q;
  assign qbar = ~q_q;
endmodule

// File: rtl/tff_counter.sv
// tff_counter: modulo-MOD up/down counter built from a row of toggle cells
module tff_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MOD   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic             up,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_n,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);
  if (!(`COUNTER_PARAMS_OK(WIDTH, MOD))) begin : g_bad_params
    $error("tff_counter: illegal WIDTH/MOD combination");
  end
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MOD - 1);
  mod_next_t nxt;
  logic [WIDTH-1:0] count_d, toggle;
  logic over, wrap_d, wrap_q, load_err_d, load_err_q;
  assign over = 32'(din) >= 32'(MOD);
  assign nxt = mod_next(16'(count), up, MOD);
  // next count with rst > load > en > hold priority; cells toggle where it differs from the current count
  always_comb begin
    count_d = rst ? '0 : load ? (over ? MAX : din) : en ? WIDTH'(nxt.value) : count;
    toggle = count ^ count_d;
    wrap_d = !rst && !load && en && nxt.wrap;
    load_err_d = !rst && load && over;
  end
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    t_ff_cell u_cell (
      .clk (clk),
      .rst (rst),
      .t   (toggle[i]),
      .q   (count[i]),
      .qbar(count_n[i])
    );
  end
  // one-cycle status pulses for the step just taken
  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_q <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
      load_err_q <= load_err_d;
    end
  end
  assign wrap = wrap_q;
  assign load_err = load_err_q;
  assign tc = (up == DIR_UP && count == MAX) || (up == DIR_DOWN && count == '0);
endmodule

// File: tb/tb_tff_counter.sv
// tb_tff_counter: scoreboard bench for tff_counter at MOD 16, 10 and 2
module tb_tff_counter;
  logic clk = 1'b0;
  logic rst = 1'b1, en = 1'b0, load = 1'b0, up = 1'b1;
  logic [3:0] din = 4'd0;
  logic [3:0] c16, cn16, c10, cn10;
  logic [1:0] c2, cn2;
  logic tc16, w16, e16, tc10, w10, e10, tc2, w2, e2;
  int checks = 0, errors = 0;
  int m16 = 0, m10 = 0, m2 = 0;

  typedef struct {
    int c16; bit w16; bit e16;
    int c10; bit w10; bit e10;
    int c2;  bit w2;  bit e2;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  tff_counter #(.WIDTH(4), .MOD(16)) dut16 (.clk(clk), .rst(rst), .en(en), .load(load), .up(up), .din(din),
    .count(c16), .count_n(cn16), .tc(tc16), .wrap(w16), .load_err(e16));
  tff_counter #(.WIDTH(4), .MOD(10)) dut10 (.clk(clk), .rst(rst), .en(en), .load(load), .up(up), .din(din),
    .count(c10), .count_n(cn10), .tc(tc10), .wrap(w10), .load_err(e10));
  tff_counter #(.WIDTH(2), .MOD(2)) dut2 (.clk(clk), .rst(rst), .en(en), .load(load), .up(up), .din(din[1:0]),
    .count(c2), .count_n(cn2), .tc(tc2), .wrap(w2), .load_err(e2));

  task automatic model(input int mod, input int d, inout int c, output bit w, output bit e);
    w = 0;
    e = 0;
    if (rst) c = 0;
    else if (load) begin
      e = d >= mod;
      c = e ? mod - 1 : d;
    end else if (en) begin
      if (up) begin
        w = (c == mod - 1);
        c = w ? 0 : c + 1;
      end else begin
        w = (c == 0);
        c = w ? mod - 1 : c - 1;
      end
    end
  endtask

  task automatic cyc(input bit r, input bit l, input bit e, input bit u, input int d);
    exp_t x;
    @(negedge clk);
    rst = r; load = l; en = e; up = u; din = 4'(d);
    model(16, d, m16, x.w16, x.e16); x.c16 = m16;
    model(10, d, m10, x.w10, x.e10); x.c10 = m10;
    model(2, d % 4, m2, x.w2, x.e2); x.c2 = m2;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t x;
    for (int i = 0; i < 2; i++) begin
      cyc(1, 0, 1, 1, 0);
      x = sb.pop_front();
    end
    checks += 5;
    if (c16 !== 4'd0) begin errors++; $display("FAIL reset_count16: got %0d want 0", c16); end
    if (cn16 !== 4'hF) begin errors++; $display("FAIL reset_count_n16: got %h want f", cn16); end
    if (w16 !== 1'b0 || e16 !== 1'b0) begin errors++; $display("FAIL reset_pulses16: wrap=%b load_err=%b want 0 0", w16, e16); end
    if (c10 !== 4'(x.c10) || cn10 !== 4'hF) begin errors++; $display("FAIL reset_count10: got %0d/%h want 0/f", c10, cn10); end
    if (c2 !== 2'd0 || cn2 !== 2'b11) begin errors++; $display("FAIL reset_count2: got %0d/%b want 0/11", c2, cn2); end
  endtask

  task automatic test_up_count();
    exp_t x;
    for (int i = 0; i < 17; i++) begin
      cyc(0, 0, 1, 1, 0);
      x = sb.pop_front();
      checks += 5;
      if (c16 !== 4'(x.c16) || c16 !== 4'((i + 1) % 16)) begin errors++; $display("FAIL up_count step %0d: got %0d want %0d", i, c16, (i + 1) % 16); end
      if (w16 !== x.w16 || w16 !== (i == 15)) begin errors++; $display("FAIL up_wrap step %0d: got %b want %b", i, w16, i == 15); end
      if (tc16 !== (x.c16 == 15)) begin errors++; $display("FAIL up_tc step %0d: got %b want %b", i, tc16, x.c16 == 15); end
      if (cn16 !== ~4'(x.c16)) begin errors++; $display("FAIL up_count_n step %0d: got %h want %h", i, cn16, ~4'(x.c16)); end
      if (c10 !== 4'(x.c10) || w10 !== x.w10) begin errors++; $display("FAIL up_mod10 step %0d: got %0d/%b want %0d/%b", i, c10, w10, x.c10, x.w10); end
    end
  endtask

  task automatic test_down_mod10();
    exp_t x;
    int seq[4] = '{1, 0, 9, 8};
    cyc(0, 1, 0, 0, 2);
    x = sb.pop_front();
    checks++;
    if (c10 !== 4'd2 || c10 !== 4'(x.c10)) begin errors++; $display("FAIL down_load: got %0d want 2", c10); end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1, 0, 0);
      x = sb.pop_front();
      checks += 3;
      if (c10 !== 4'(seq[i]) || c10 !== 4'(x.c10)) begin errors++; $display("FAIL down_count step %0d: got %0d want %0d", i, c10, seq[i]); end
      if (w10 !== (i == 2) || w10 !== x.w10) begin errors++; $display("FAIL down_wrap step %0d: got %b want %b", i, w10, i == 2); end
      if (tc10 !== (seq[i] == 0)) begin errors++; $display("FAIL down_tc step %0d: got %b want %b", i, tc10, seq[i] == 0); end
    end
  endtask

  task automatic test_load_err();
    exp_t x;
    cyc(0, 1, 0, 1, 13);
    x = sb.pop_front();
    checks += 3;
    if (c10 !== 4'd9 || e10 !== 1'b1 || w10 !== 1'b0) begin errors++; $display("FAIL load_err10: count=%0d load_err=%b wrap=%b want 9 1 0", c10, e10, w10); end
    if (e10 !== x.e10) begin errors++; $display("FAIL load_err10_model: got %b want %b", e10, x.e10); end
    if (c16 !== 4'd13 || e16 !== 1'b0) begin errors++; $display("FAIL load_ok16: count=%0d load_err=%b want 13 0", c16, e16); end
    cyc(0, 0, 0, 1, 0);
    x = sb.pop_front();
    checks++;
    if (e10 !== 1'b0 || c10 !== 4'(x.c10)) begin errors++; $display("FAIL load_err_pulse: load_err=%b count=%0d want 0 9", e10, c10); end
  endtask

  task automatic test_collision();
    exp_t x;
    cyc(0, 1, 0, 1, 5);
    x = sb.pop_front();
    cyc(0, 1, 1, 1, 3);
    x = sb.pop_front();
    checks += 2;
    if (c16 !== 4'd3 || w16 !== 1'b0) begin errors++; $display("FAIL collision16: count=%0d wrap=%b want 3 0", c16, w16); end
    if (c10 !== 4'(x.c10) || w10 !== 1'b0) begin errors++; $display("FAIL collision10: count=%0d wrap=%b want %0d 0", c10, w10, x.c10); end
    cyc(0, 1, 0, 1, 9);
    x = sb.pop_front();
    cyc(0, 1, 1, 1, 9);
    x = sb.pop_front();
    checks++;
    if (c10 !== 4'd9 || w10 !== 1'b0) begin errors++; $display("FAIL collision_at_max: count=%0d wrap=%b want 9 0", c10, w10); end
  endtask

  task automatic test_mid_reset();
    exp_t x;
    cyc(0, 1, 0, 1, 15);
    x = sb.pop_front();
    checks++;
    if (tc16 !== 1'b1 || e10 !== 1'b1) begin errors++; $display("FAIL mid_reset_setup: tc=%b load_err10=%b want 1 1", tc16, e10); end
    cyc(1, 0, 1, 1, 0);
    x = sb.pop_front();
    checks += 2;
    if (c16 !== 4'd0 || w16 !== 1'b0 || cn16 !== 4'hF) begin errors++; $display("FAIL mid_reset16: count=%0d wrap=%b count_n=%h want 0 0 f", c16, w16, cn16); end
    if (e10 !== 1'b0 || c10 !== 4'(x.c10)) begin errors++; $display("FAIL mid_reset10: load_err=%b count=%0d want 0 0", e10, c10); end
  endtask

  task automatic test_dir_flip();
    exp_t x;
    int seq[3] = '{1, 0, 15};
    bit dir[3] = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, dir[i], 0);
      x = sb.pop_front();
      checks += 2;
      if (c16 !== 4'(seq[i]) || c16 !== 4'(x.c16)) begin errors++; $display("FAIL flip_count step %0d: got %0d want %0d", i, c16, seq[i]); end
      if (w16 !== (i == 2)) begin errors++; $display("FAIL flip_wrap step %0d: got %b want %b", i, w16, i == 2); end
      if (i == 1) begin
        checks += 2;
        if (tc16 !== 1'b1) begin errors++; $display("FAIL flip_tc_down: got %b want 1", tc16); end
        up = 1'b1;
        #1;
        if (tc16 !== 1'b0) begin errors++; $display("FAIL flip_tc_up: got %b want 0", tc16); end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t x;
    cyc(1, 0, 0, 1, 0);
    x = sb.pop_front();
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 1, i >= 3, 0);
      x = sb.pop_front();
      checks += 2;
      if (c2 !== 2'(x.c2) || cn2 !== ~2'(x.c2)) begin errors++; $display("FAIL b2b_count step %0d: got %0d/%b want %0d", i, c2, cn2, x.c2); end
      if (w2 !== x.w2) begin errors++; $display("FAIL b2b_wrap step %0d: got %b want %b", i, w2, x.w2); end
    end
  endtask

  initial begin
    test_reset();
    test_up_count();
    test_down_mod10();
    test_load_err();
    test_collision();
    test_mid_reset();
    test_dir_flip();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
